// File: rtl/gate_tt_checker_pkg.sv
// Shared types and expected-output masks for the 2-input gate truth-table checker.
// The expected Y for a vector is one bit of the mask selected by the vector index.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_NAND = 2'd1,
        OP_XNOR = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] MASK_AND  = 4'b1000;
    localparam logic [3:0] MASK_NAND = 4'b0111;
    localparam logic [3:0] MASK_XNOR = 4'b1001;

    function automatic logic expected_y(input op_e op, input logic [1:0] idx);
        logic [3:0] mask_v;
        case (op)
            OP_AND:  mask_v = MASK_AND;
            OP_NAND: mask_v = MASK_NAND;
            OP_XNOR: mask_v = MASK_XNOR;
            default: mask_v = 4'b0000;
        endcase
        return mask_v[idx];
    endfunction

endpackage

// File: rtl/gate_tt_checker_if.sv
// Control, result and gate-side signals of the truth-table checker.
// The checker is the slave; the controlling logic and the gate under test sit on the master side.
interface gate_tt_checker_if;
    logic       start;
    logic [1:0] op_sel;
    logic       a_out;
    logic       b_out;
    logic       y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic       bad_op;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        output start, op_sel, y_in,
        input  a_out, b_out, busy, done, pass, bad_op, err_count, fail_vec
    );

    modport slave (
        input  start, op_sel, y_in,
        output a_out, b_out, busy, done, pass, bad_op, err_count, fail_vec
    );
endinterface

// File: rtl/gate_tt_checker.sv
// Sequential truth-table driver/checker for 2-input gates: walks the four A/B vectors,
// waits SETTLE_CYCLES edges per vector, and accumulates a per-vector mismatch summary.
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_tt_checker_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_APPLY = APPLY;
    localparam logic [1:0] S_DONE  = DONE;
    localparam logic [3:0] RELOAD  = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_r;
    logic [1:0] idx_r;
    logic [3:0] cnt_r;
    op_e        op_r;
    logic       a_r;
    logic       b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic       bad_op_r;
    logic [2:0] err_r;
    logic [3:0] fail_r;

    logic       mismatch_s;
    logic [3:0] fail_next_s;
    logic [2:0] err_next_s;
    logic [1:0] idx_inc_s;

    // Score the vector currently on the gate inputs
    always_comb begin
        mismatch_s  = (bus.y_in != expected_y(op_r, idx_r));
        idx_inc_s   = idx_r + 2'd1;
        fail_next_s = fail_r;
        err_next_s  = err_r;
        if (mismatch_s) begin
            fail_next_s = fail_r | (4'b0001 << idx_r);
            err_next_s  = err_r + 3'd1;
        end else begin
            fail_next_s = fail_r;
            err_next_s  = err_r;
        end
    end

    // Run control, vector sequencing and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            idx_r    <= 2'd0;
            cnt_r    <= 4'd0;
            op_r     <= OP_AND;
            a_r      <= 1'b0;
            b_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            bad_op_r <= 1'b0;
            err_r    <= 3'd0;
            fail_r   <= 4'd0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        idx_r  <= 2'd0;
                        a_r    <= 1'b0;
                        b_r    <= 1'b0;
                        pass_r <= 1'b0;
                        err_r  <= 3'd0;
                        fail_r <= 4'd0;
                        if (bus.op_sel == OP_RSVD) begin
                            // Reserved op: report immediately without driving any vector
                            state_r  <= S_DONE;
                            bad_op_r <= 1'b1;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            state_r  <= S_APPLY;
                            op_r     <= op_e'(bus.op_sel);
                            bad_op_r <= 1'b0;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                            cnt_r    <= RELOAD;
                        end
                    end
                end
                S_APPLY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        fail_r <= fail_next_s;
                        err_r  <= err_next_s;
                        if (idx_r != 2'd3) begin
                            idx_r <= idx_inc_s;
                            a_r   <= idx_inc_s[1];
                            b_r   <= idx_inc_s[0];
                            cnt_r <= RELOAD;
                        end else begin
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            a_r     <= 1'b0;
                            b_r     <= 1'b0;
                            pass_r  <= (fail_next_s == 4'd0);
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_out     = a_r;
    assign bus.b_out     = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.bad_op    = bad_op_r;
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fail_r;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench: two checkers (settle 1 and 3) each drive a modelled 2-input gate;
// expected run summaries are queued at start and popped when done rises.
module tb_gate_tt_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gate_tt_checker_if bus1();
    gate_tt_checker_if bus3();

    gate_tt_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    gate_tt_checker #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    localparam int G_AND = 0, G_NAND = 1, G_XNOR = 2, G_ONE = 3;
    int kind1 = G_AND;
    int kind3 = G_AND;

    function automatic logic gate_y(input int k, input logic a, input logic b);
        case (k)
            G_AND:   return a & b;
            G_NAND:  return ~(a & b);
            G_XNOR:  return ~(a ^ b);
            default: return 1'b1;
        endcase
    endfunction

    assign bus1.y_in = gate_y(kind1, bus1.a_out, bus1.b_out);
    assign bus3.y_in = gate_y(kind3, bus3.a_out, bus3.b_out);

    typedef struct {
        int         when;
        logic       pass;
        logic       bad_op;
        logic [2:0] err;
        logic [3:0] fv;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push1(input int when, input logic p, input logic bo, input logic [2:0] e, input logic [3:0] fv);
        exp_t x;
        x.when = when; x.pass = p; x.bad_op = bo; x.err = e; x.fv = fv;
        q1.push_back(x);
    endtask

    task automatic push3(input int when, input logic p, input logic bo, input logic [2:0] e, input logic [3:0] fv);
        exp_t x;
        x.when = when; x.pass = p; x.bad_op = bo; x.err = e; x.fv = fv;
        q3.push_back(x);
    endtask

    // Monitors: compare a result whenever done rises
    logic done1_prev = 1'b0;
    logic done3_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done1_prev = 1'b0;
        end else begin
            if (bus1.done && !done1_prev) begin
                if (q1.size() == 0) begin
                    check("d1_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("d1_done_cycle", cyc, e.when);
                    check("d1_pass", {31'd0, bus1.pass}, {31'd0, e.pass});
                    check("d1_bad_op", {31'd0, bus1.bad_op}, {31'd0, e.bad_op});
                    check("d1_err_count", {29'd0, bus1.err_count}, {29'd0, e.err});
                    check("d1_fail_vec", {28'd0, bus1.fail_vec}, {28'd0, e.fv});
                end
            end
            done1_prev = bus1.done;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done3_prev = 1'b0;
        end else begin
            if (bus3.done && !done3_prev) begin
                if (q3.size() == 0) begin
                    check("d3_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q3.pop_front();
                    check("d3_done_cycle", cyc, e.when);
                    check("d3_pass", {31'd0, bus3.pass}, {31'd0, e.pass});
                    check("d3_bad_op", {31'd0, bus3.bad_op}, {31'd0, e.bad_op});
                    check("d3_err_count", {29'd0, bus3.err_count}, {29'd0, e.err});
                    check("d3_fail_vec", {28'd0, bus3.fail_vec}, {28'd0, e.fv});
                end
            end
            done3_prev = bus3.done;
        end
    end

    task automatic start1(input logic [1:0] op, output int t0);
        @(negedge clk);
        bus1.start = 1'b1; bus1.op_sel = op;
        @(posedge clk); #1;
        t0 = cyc;
        bus1.start = 1'b0;
    endtask

    task automatic start3(input logic [1:0] op, output int t0);
        @(negedge clk);
        bus3.start = 1'b1; bus3.op_sel = op;
        @(posedge clk); #1;
        t0 = cyc;
        bus3.start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check(name, q1.size() + q3.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs1"}, {23'd0, bus1.a_out, bus1.b_out, bus1.busy, bus1.done, bus1.pass,
               bus1.bad_op, bus1.err_count}, 32'd0);
        check({tag, "_fv1"}, {28'd0, bus1.fail_vec}, 32'd0);
        check({tag, "_outs3"}, {23'd0, bus3.a_out, bus3.b_out, bus3.busy, bus3.done, bus3.pass,
               bus3.bad_op, bus3.err_count}, 32'd0);
        check({tag, "_fv3"}, {28'd0, bus3.fail_vec}, 32'd0);
    endtask

    initial begin
        int t0;
        int busy_n;
        bus1.start = 1'b0; bus1.op_sel = 2'd0;
        bus3.start = 1'b0; bus3.op_sel = 2'd0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1: AND gate, op AND, settle 1
        kind1 = G_AND;
        start1(2'd0, t0);
        push1(t0 + 4, 1'b1, 1'b0, 3'd0, 4'b0000);
        check("t1_vec0", {30'd0, bus1.a_out, bus1.b_out}, 32'd0);
        check("t1_busy", {31'd0, bus1.busy}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check("t1_vec", {30'd0, bus1.a_out, bus1.b_out}, i);
        end
        drain("t1_drain", 20);

        // 2: XNOR gate while expecting NAND -> vectors 1,2,3 mismatch
        kind1 = G_XNOR;
        start1(2'd1, t0);
        push1(t0 + 4, 1'b0, 1'b0, 3'd3, 4'b1110);
        drain("t2_drain", 20);

        // 3: XNOR gate, op XNOR, settle 3
        kind3 = G_XNOR;
        start3(2'd2, t0);
        push3(t0 + 12, 1'b1, 1'b0, 3'd0, 4'b0000);
        busy_n = 0;
        for (int k = 0; k < 16; k++) begin
            if (bus3.busy) busy_n++;
            if (k == 2) check("t3_hold_vec0", {30'd0, bus3.a_out, bus3.b_out}, 32'd0);
            if (k == 3) check("t3_vec1", {30'd0, bus3.a_out, bus3.b_out}, 32'd1);
            if (k == 8) check("t3_vec2", {30'd0, bus3.a_out, bus3.b_out}, 32'd2);
            @(posedge clk); #1;
        end
        check("t3_busy_cycles", busy_n, 32'd12);
        drain("t3_drain", 20);

        // 4: reserved op after a reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        start1(2'd3, t0);
        push1(t0, 1'b0, 1'b1, 3'd0, 4'b0000);
        check("t4_done_now", {31'd0, bus1.done}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("t4_no_busy_ab", {29'd0, bus1.busy, bus1.a_out, bus1.b_out}, 32'd0);
            @(posedge clk); #1;
        end
        drain("t4_drain", 20);

        // 5: start during APPLY ignored, reset mid-run, then clean run
        kind3 = G_AND;
        start3(2'd0, t0);
        @(negedge clk);
        bus3.start = 1'b1; bus3.op_sel = 2'd3;
        @(posedge clk); #1;
        bus3.start = 1'b0; bus3.op_sel = 2'd0;
        check("t5_busy_kept", {30'd0, bus3.busy, bus3.done}, 32'd2);
        check("t5_no_bad_op", {31'd0, bus3.bad_op}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_vec2", {30'd0, bus3.a_out, bus3.b_out}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_reset");
        @(negedge clk); rst_n = 1'b1;
        start3(2'd0, t0);
        push3(t0 + 12, 1'b1, 1'b0, 3'd0, 4'b0000);
        drain("t5_drain", 30);

        // 6: start held high, Y stuck at 1, op AND -> back-to-back runs
        kind1 = G_ONE;
        @(negedge clk);
        bus1.start = 1'b1; bus1.op_sel = 2'd0;
        @(posedge clk); #1;
        t0 = cyc;
        push1(t0 + 4, 1'b0, 1'b0, 3'd3, 4'b0111);
        push1(t0 + 9, 1'b0, 1'b0, 3'd3, 4'b0111);
        push1(t0 + 14, 1'b0, 1'b0, 3'd3, 4'b0111);
        while (cyc < t0 + 14) begin
            @(posedge clk); #1;
            if (cyc == t0 + 5) check("t6_done_one_cycle", {30'd0, bus1.done, bus1.busy}, 32'd1);
        end
        bus1.start = 1'b0;
        drain("t6_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
